wide_add_sequencer: RTL and testbench

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

---
 rtl/wide_add_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_wide_add_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
//
// Performs a W = N*K bit addition by walking K slices through an external
// N-bit ripple-carry adder, one slice per clock, least-significant slice first.
// The slice carry-out is registered and fed back as the next slice carry-in.
//
// Optional feature (compile-time macro WIDE_ADD_SUB_EN):
//   Adds input 'sub'. When sub=1 at an accepted start, ~b and a carry-in of 1
//   are latched instead of b and cin, so the sequence computes a - b.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   request an addition (only honoured in IDLE)
//   sub       in   (WIDE_ADD_SUB_EN only) select subtraction
//   a, b      in   W-bit operands, latched on accepted start
//   cin       in   carry-in, latched on accepted start
//   busy      out  high while an operation is in RUN or DONE
//   done      out  one-cycle pulse: sum/cout are valid
//   sum       out  W-bit result register
//   cout      out  final carry-out register
//   add_a     out  N-bit slice operand A to the external adder
//   add_b     out  N-bit slice operand B to the external adder
//   add_cin   out  slice carry-in to the external adder
//   add_sum   in   N-bit slice sum from the external adder
//   add_cout  in   slice carry-out from the external adder
// -----------------------------------------------------------------------------
module wide_add_sequencer #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
`ifdef WIDE_ADD_SUB_EN
  input  logic           sub,
`endif
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] sum,
  output logic           cout,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_cout
);

  localparam int W     = N * K;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic             cin_q,   cin_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             cout_q,  cout_d;

  // Operand values as they are to be captured on an accepted start.
  logic [W-1:0]     b_in;
  logic             cin_in;

`ifdef WIDE_ADD_SUB_EN
  // Two's-complement subtraction: a - b = a + ~b + 1.
  assign b_in   = sub ? ~b   : b;
  assign cin_in = sub ? 1'b1 : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_in;
          cin_d   = cin_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int s = 0; s < K; s++) begin
          if (idx_q == IDX_W'(s)) sum_d[s*N +: N] = add_sum;
        end
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Index parks on the last slice rather than wrapping.
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: operand and result registers are reset along with the control state
  // so that an aborted operation leaves no stale data visible on sum/cout.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // computed for this edge, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // External adder drive: slice mux during RUN, forced to zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      for (int s = 0; s < K; s++) begin
        if (idx_q == IDX_W'(s)) begin
          add_a = a_q[s*N +: N];
          add_b = b_q[s*N +: N];
        end
      end
      add_cin = (idx_q == '0) ? cin_q : carry_q;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wide_add_sequencer
//
// Directed bench for wide_add_sequencer with N=8, K=4. The external adder is
// an exact N-bit add. Expected {cout,sum} values are pushed to a queue at
// start and popped when done is observed. Slice operands and the carry chain
// seen on add_cin are predicted from the latched operands.
// Define WIDE_ADD_SUB_EN to also exercise the subtract option.
// -----------------------------------------------------------------------------
module tb_wide_add_sequencer;

  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
`ifdef WIDE_ADD_SUB_EN
  logic           sub;
`endif
  logic [W-1:0]   a, b;
  logic           cin;
  logic           busy, done, cout;
  logic [W-1:0]   sum;
  logic [N-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout;

  int checks = 0;
  int errors = 0;
  logic [W:0] expq[$];

  wide_add_sequencer #(.N(N), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef WIDE_ADD_SUB_EN
    .sub      (sub),
`endif
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External ripple-carry slice adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_adder_idle(input string tag);
    check({tag, "_add_a"},   {1'b0, {(W-N){1'b0}}, add_a}, '0);
    check({tag, "_add_b"},   {1'b0, {(W-N){1'b0}}, add_b}, '0);
    check({tag, "_add_cin"}, {{W{1'b0}}, add_cin},         '0);
  endtask

  // Issue one operation at a negedge and follow it through RUN and DONE.
  // poke re-asserts start with a different operand two cycles in.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub, input bit poke);
    logic [W-1:0] be;
    logic         ce, c;
    logic [N:0]   t;
    logic [W:0]   exp, got;
    int           s;
    be  = tsub ? ~tb_v : tb_v;
    ce  = tsub ? 1'b1 : tcin;
    exp = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ce};
    expq.push_back(exp);

    a = ta; b = tb_v; cin = tcin;
`ifdef WIDE_ADD_SUB_EN
    sub = tsub;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs to show the DUT works from its latched copies.
    a = $urandom; b = $urandom; cin = ~tcin;

    c = ce;
    for (int cyc = 1; cyc <= K + 1; cyc++) begin
      check("busy", {{W{1'b0}}, busy}, 1);
      if (cyc <= K) begin
        s = cyc - 1;
        check("run_done_low", {{W{1'b0}}, done}, 0);
        check("add_a", {1'b0, {(W-N){1'b0}}, add_a}, {1'b0, {(W-N){1'b0}}, ta[s*N +: N]});
        check("add_b", {1'b0, {(W-N){1'b0}}, add_b}, {1'b0, {(W-N){1'b0}}, be[s*N +: N]});
        check("add_cin", {{W{1'b0}}, add_cin}, {{W{1'b0}}, c});
        t = {1'b0, ta[s*N +: N]} + {1'b0, be[s*N +: N]} + {{N{1'b0}}, c};
        c = t[N];
      end else begin
        check("done", {{W{1'b0}}, done}, 1);
        check_adder_idle("done");
        if (expq.size() > 0) begin
          got = expq.pop_front();
          check("sum",  {1'b0, sum},         {1'b0, got[W-1:0]});
          check("cout", {{W{1'b0}}, cout},   {{W{1'b0}}, got[W]});
        end else begin
          check("scoreboard_nonempty", 0, 1);
        end
      end
      if (poke && cyc == 2) begin
        start = 1'b1;
        a     = 32'h12345678;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end

    // Back in IDLE: busy released, result held, adder port quiet.
    check("idle_busy", {{W{1'b0}}, busy}, 0);
    check("idle_done", {{W{1'b0}}, done}, 0);
    check("hold_sum",  {1'b0, sum},       {1'b0, exp[W-1:0]});
    check("hold_cout", {{W{1'b0}}, cout}, {{W{1'b0}}, exp[W]});
    check_adder_idle("idle");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub = 1'b0;
`endif
    @(negedge clk);
    check("rst_busy", {{W{1'b0}}, busy}, 0);
    check("rst_done", {{W{1'b0}}, done}, 0);
    check("rst_sum",  {1'b0, sum},       0);
    check("rst_cout", {{W{1'b0}}, cout}, 0);
    check_adder_idle("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single carry out of slice 0: add_cin runs 0,1,0,0.
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
    // Carry ripples through every slice and out.
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    // Start re-pulsed mid-RUN is ignored.
    run_op(32'h80000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
    run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 0);

    // Reset in the middle of RUN aborts with no done pulse.
    a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {{W{1'b0}}, busy}, 0);
    check("abort_done", {{W{1'b0}}, done}, 0);
    check("abort_sum",  {1'b0, sum},       0);
    check("abort_cout", {{W{1'b0}}, cout}, 0);
    check_adder_idle("abort");
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_done", {{W{1'b0}}, done}, 0);
      check("post_abort_busy", {{W{1'b0}}, busy}, 0);
    end
    run_op(32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0, 0);

`ifdef WIDE_ADD_SUB_EN
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0);
    run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 0);
`endif

    check("scoreboard_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
